// File: rtl/filter_event_arbiter.sv
// Two-channel event arbiter: per-channel FIFOs feeding a round-robin granted output register.
// Optional macro FILTER_EVENT_ARBITER_DROP_CNT_EN adds saturating per-channel lost-event counters.

module filter_event_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [15:0]           addr,
    input  logic                  valid,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_value,
    output logic [15:0]           head_addr,
    output logic                  nonempty,
    output logic                  ready
`ifdef FILTER_EVENT_ARBITER_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);

    logic [DATA_WIDTH+15:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count, count_nxt;
    logic                   full, push;

    assign full     = (count == FULL_CNT);
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push     = valid && (!full || pop);
    assign nonempty = (count != '0);
    assign {head_value, head_addr} = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            // One slot held back for the producer's in-flight event.
            ready <= (count_nxt <= READY_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {value, addr};
    end

`ifdef FILTER_EVENT_ARBITER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (valid && !push && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

module filter_event_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in0_event_value,
    input  logic [15:0]           in0_event_addr,
    input  logic                  in0_event_valid,
    input  logic [DATA_WIDTH-1:0] in1_event_value,
    input  logic [15:0]           in1_event_addr,
    input  logic                  in1_event_valid,
    output logic                  ready_for_new_event0,
    output logic                  ready_for_new_event1,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_event_value,
    output logic [15:0]           out_event_addr,
    output logic                  out_event_src,
    output logic                  out_event_valid
`ifdef FILTER_EVENT_ARBITER_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt0,
    output logic [15:0]           drop_cnt1
`endif
);
    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} arb_state_t;

    logic [1:0][DATA_WIDTH-1:0] in_value, head_value;
    logic [1:0][15:0]           in_addr, head_addr;
    logic [1:0]                 in_valid, pop, nonempty, ready;
`ifdef FILTER_EVENT_ARBITER_DROP_CNT_EN
    logic [1:0][15:0]           drop_cnt;
    assign drop_cnt0 = drop_cnt[0];
    assign drop_cnt1 = drop_cnt[1];
`endif

    arb_state_t state, state_nxt;
    logic       load, grant_vld, grant_src;

    assign in_value = {in1_event_value, in0_event_value};
    assign in_addr  = {in1_event_addr,  in0_event_addr};
    assign in_valid = {in1_event_valid, in0_event_valid};
    assign ready_for_new_event0 = ready[0];
    assign ready_for_new_event1 = ready[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        filter_event_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .value      (in_value[c]),
            .addr       (in_addr[c]),
            .valid      (in_valid[c]),
            .pop        (pop[c]),
            .head_value (head_value[c]),
            .head_addr  (head_addr[c]),
            .nonempty   (nonempty[c]),
            .ready      (ready[c])
`ifdef FILTER_EVENT_ARBITER_DROP_CNT_EN
            ,
            .drop_cnt   (drop_cnt[c])
`endif
        );
        assign pop[c] = grant_vld && (grant_src == c[0]);
    end

    assign load = !out_event_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PRI0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_src = 1'b0;
        if (load) begin
            case (state)
                PRI0: begin
                    if (nonempty[0])      begin grant_vld = 1'b1; grant_src = 1'b0; end
                    else if (nonempty[1]) begin grant_vld = 1'b1; grant_src = 1'b1; end
                end
                default: begin
                    if (nonempty[1])      begin grant_vld = 1'b1; grant_src = 1'b1; end
                    else if (nonempty[0]) begin grant_vld = 1'b1; grant_src = 1'b0; end
                end
            endcase
            if (grant_vld) state_nxt = grant_src ? PRI0 : PRI1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_event_valid <= 1'b0;
            out_event_value <= '0;
            out_event_addr  <= '0;
            out_event_src   <= 1'b0;
        end else if (load) begin
            out_event_valid <= grant_vld;
            if (grant_vld) begin
                out_event_value <= head_value[grant_src];
                out_event_addr  <= head_addr[grant_src];
                out_event_src   <= grant_src;
            end
        end
    end
endmodule
